enemy_row_phase_controller: RTL

Sequential controller that owns one row of enemies and produces the phase and alive information that the combinational per-enemy movement logic consumes. It registers the row base X coordinate, the 2-bit movement phase, the per-enemy alive mask and the frame/step counters. From these it publishes each enemy's 19-bit `{x[9:0], y[8:0]}` position, or the all-ones NONE code when that enemy is dead. It sits between the game-state/collision logic (frame tick, start, hit reports) and the sprite renderer.

---
 rtl/enemy_row_phase_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/enemy_row_phase_controller.sv
// enemy_row_phase_controller
// Owns one row of enemies: registers the row base X, the 2-bit movement
// phase, the alive mask and the frame/step counters, and publishes each
// enemy's {x, y} position (or NONE when dead) to the sprite renderer.
module enemy_row_phase_controller #(
    parameter int          ENEMY_COUNT       = 8,
    parameter logic [9:0]  SPACING           = 10'd48,
    parameter logic [9:0]  INIT_X            = 10'd152,
    parameter logic [8:0]  VERTICAL_POSITION = 9'd48,
    parameter int          FRAME_DIV         = 4,
    parameter int          STEPS_PER_PHASE   = 32,
    parameter logic [18:0] NONE              = {19{1'b1}},
    parameter int          IDX_W             = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_Start,
    input  logic                      i_FrameTick,
    input  logic                      i_HitValid,
    input  logic [IDX_W-1:0]          i_HitIndex,
    output logic [1:0]                o_PhaseState,
    output logic [ENEMY_COUNT-1:0]    o_EnemyState,
    output logic [19*ENEMY_COUNT-1:0] o_EnemyPosition,
    output logic                      o_RowCleared
);

    // Encoding keeps CLEARED in its own bit so o_RowCleared is a plain flop.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_CLEARED = 2'b10;

    localparam int FRAME_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int STEP_W  = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_PER_PHASE - 1);
    localparam logic [IDX_W:0]     HIT_LIMIT  = (IDX_W + 1)'(ENEMY_COUNT);

    logic [1:0]             state;
    logic [9:0]             baseX;
    logic [1:0]             phase;
    logic [FRAME_W-1:0]     frameCnt;
    logic [STEP_W-1:0]      stepCnt;
    logic [ENEMY_COUNT-1:0] alive;

    logic [ENEMY_COUNT-1:0] hitMask;
    logic [ENEMY_COUNT-1:0] aliveAfterHit;
    logic                   stepNow;
    logic                   movingRight;

    // Decode the hit report into a one-hot kill mask; out-of-range indices kill nothing.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        hitMask = '0;
        if (i_HitValid && ({1'b0, i_HitIndex} < HIT_LIMIT)) begin
            hitMask[i_HitIndex] = 1'b1;
        end
    end

    assign aliveAfterHit = alive & ~hitMask;
    assign stepNow       = i_FrameTick && (frameCnt == FRAME_LAST);
    // Phases 01 and 10 move right; 00 and 11 move left.
    assign movingRight   = phase[0] ^ phase[1];

    // Row state: start reinitialises, RUN advances movement and applies hits.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= ST_IDLE;
            baseX    <= INIT_X;
            phase    <= 2'b00;
            frameCnt <= '0;
            stepCnt  <= '0;
            alive    <= '0;
        end else if (i_Start) begin
            state    <= ST_RUN;
            baseX    <= INIT_X;
            phase    <= 2'b00;
            frameCnt <= '0;
            stepCnt  <= '0;
            alive    <= '1;
        end else if (state == ST_RUN) begin
            if (i_FrameTick) begin
                if (stepNow) begin
                    frameCnt <= '0;
                    baseX    <= movingRight ? baseX + 10'd1 : baseX - 10'd1;
                    if (stepCnt == STEP_LAST) begin
                        stepCnt <= '0;
                        phase   <= phase + 2'd1;
                    end else begin
                        stepCnt <= stepCnt + STEP_W'(1);
                    end
                end else begin
                    frameCnt <= frameCnt + FRAME_W'(1);
                end
            end
            alive <= aliveAfterHit;
            if (aliveAfterHit == '0) begin
                state <= ST_CLEARED;
            end
        end
    end

    // Per-enemy position: fixed offset from the base, modulo-1024 in X.
    for (genvar i = 0; i < ENEMY_COUNT; i++) begin : g_pos
        localparam logic [9:0] OFFSET = 10'((i * int'(SPACING)) % 1024);
        assign o_EnemyPosition[19*i +: 19] = alive[i] ? {baseX + OFFSET, VERTICAL_POSITION} : NONE;
    end

    assign o_PhaseState = phase;
    assign o_EnemyState = alive;
    assign o_RowCleared = state[1];

endmodule
